net_decoupler_mc: RTL
=====================

// Module: net_decoupler_mc
// PURPOSE
//  Multi-channel, per-tenant network decoupler. NUM_CHAN independent egress/ingress AXIS pairs.
//  Each channel is decoupled at packet boundaries, with a bounded egress drain timeout.
//  Sits between each vFPGA region and the shared NIC datapath, ahead of the egress protocol corrector.
// PARAMETERS
//  NUM_CHAN                    4   number of tenant channels (1..16)
//  AXIS_BUS_WIDTH             64   tdata width per channel; tkeep = AXIS_BUS_WIDTH/8
//  AXIS_ID_WIDTH               4   tid/tdest width; 0 maps to 1-bit port
//  DRAIN_TIMEOUT            1024   cycles allowed in egress DRAIN; 0 = no timeout
//  DISALLOW_INGR_BACKPRESSURE  1   1: ingress in_tready tied to 1
// PORTS  (per-channel buses flattened, channel c at slice [c*W +: W])
//  aclk                     in   1             clock
//  aresetn                  in   1             synchronous, active-low reset
//  axis_egr_in_*            in   N*{W,ID,ID,W/8,1,1}  tdata,tid,tdest,tkeep,tlast,tvalid from tenants
//  axis_egr_in_tready       out  N             ready to tenants
//  axis_egr_out_*           out  N*{...}       same set toward NIC; axis_egr_out_tready in N
//  axis_egr_tlast_forced    in   N             tlast injected by protocol corrector
//  axis_ingr_in_*           in   N*{W,ID,W/8,1,1}     tdata,tdest,tkeep,tlast,tvalid from NIC; tready out N
//  axis_ingr_out_*          out  N*{...}       toward tenants; axis_ingr_out_tready in N
//  decouple                 in   N             graceful decouple request per channel
//  decouple_force           in   N             immediate decouple, both directions
//  decouple_done            out  N             channel fully decoupled under request
//  decouple_status_vector   out  2N            [2c]=egress decoupled, [2c+1]=ingress decoupled
//  egr_timeout              out  N             sticky: drain timed out; cleared when decouple[c] falls
// BEHAVIOUR
//  - Only tvalid and tready are gated. All data sideband passes straight through.
//  - Reset: all channels COUPLED, counters 0, all outputs 0 except pass-through and tied tready.
//  - Egress FSM per channel: COUPLED -> DRAIN -> DECOUPLED.
//    outst = beat accepted without (tlast|tlast_forced); cleared on tlast beat.
//    COUPLED: pass. On req = decouple|force:
//      outst=0 -> DECOUPLED, combinationally in same cycle (gating effective immediately);
//      else -> DRAIN.
//    DRAIN: pass; counter++ each cycle.
//      On tlast/tlast_forced handshake -> DECOUPLED.
//      On decouple_force -> DECOUPLED.
//      On counter==DRAIN_TIMEOUT-1 (if nonzero) -> DECOUPLED and set egr_timeout.
//      On req deassert -> COUPLED. Counter cleared on exit.
//    DECOUPLED: out_tvalid=0, in_tready=0. Req low -> COUPLED next cycle with outst cleared.
//    Simultaneous final tlast handshake and timeout: treated as clean, no timeout flag.
//  - Ingress per channel, registered state:
//    decoupled <= force | (decouple & !outst_nxt); cleared only when !decouple & !force & !outst_nxt.
//    Exit happens only at a boundary, so tenants never see a partial packet.
//    Decoupled: out_tvalid=0, in_tready=1 (beats dropped).
//    outst_nxt is computed from the in_tvalid & in_tready handshake, independent of gating.
//  - decouple_done[c] = decouple[c] & egr DECOUPLED & ingr decoupled & !ingr outst.
//  - Channels are fully independent; no cross-channel arbitration or shared state.
//  - Reset mid-packet: state discarded. Downstream relies on protocol corrector for truncation.
// CONFIGURATION
//  `NET_DECOUP_DROP_CNT_EN defined:
//    adds output ingr_drop_count [N*32] (per channel).
//    Increments on each ingress beat dropped while decoupled; saturates at 2^32-1.
//    Reset 0 only; not cleared on recouple.
//  Undefined: port and counters absent; behaviour otherwise identical.
// STRUCTURE
//  net_decoup_pkg: egress state localparams (COUPLED=0, DRAIN=1, DECOUPLED=2), state width,
//    timeout counter width $clog2(DRAIN_TIMEOUT+1), drop counter width.
//  Sub-module net_decoup_chan: one channel, both directions.
//  Top instantiates NUM_CHAN copies in a generate loop and slices the buses.
// TESTING
//  1. Idle ch1, decouple[1]=1 -> same cycle egr_out_tvalid[1]=0; status bits 2,3 =1 next cycle;
//     done[1]=1; ch0 traffic unaffected.
//  2. Ch0 egress 8-beat pkt, decouple at beat 3 -> beats 4..8 pass; DECOUPLED after beat 8 handshake;
//     egr_timeout[0]=0.
//  3. DRAIN_TIMEOUT=16, ch2 mid-pkt, tenant stalls tvalid -> DECOUPLED at cycle 16;
//     egr_timeout[2]=1 until decouple[2] falls.
//  4. Ingress 4-beat pkt in flight, decouple -> pkt completes to tenant; next 5-beat pkt dropped,
//     in_tready=1; with DROP_CNT_EN count=5.
//  5. decouple_force[3] mid-packet both directions -> both status bits 1 next cycle;
//     release -> recouple only at an ingress boundary.
//  6. aresetn low mid-DRAIN for 2 cycles -> all channels COUPLED, flags/counters 0.

Source files
------------

// File: rtl/net_decoup_pkg.sv
// rtl/net_decoup_pkg.sv - shared egress state encoding and counter widths for the network decoupler
package net_decoup_pkg;

  localparam int EGR_STATE_W = 2;

  typedef enum logic [EGR_STATE_W-1:0] {
    EGR_COUPLED   = 2'd0,
    EGR_DRAIN     = 2'd1,
    EGR_DECOUPLED = 2'd2
  } egr_state_e;

  localparam int DROP_CNT_W = 32;

  // Drain counter must hold DRAIN_TIMEOUT-1; keep at least one bit when the timeout is disabled.
  function automatic int tmo_cnt_w(input int drain_timeout);
    return (drain_timeout < 1) ? 1 : $clog2(drain_timeout + 1);
  endfunction

endpackage

// File: rtl/net_decoupler_mc_if.sv
// rtl/net_decoupler_mc_if.sv - flattened per-channel egress/ingress AXIS buses of the decoupler
interface net_decoupler_mc_if #(
  parameter int NUM_CHAN       = 4,
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4
);
  localparam int DW = NUM_CHAN * AXIS_BUS_WIDTH;
  localparam int IW = NUM_CHAN * ((AXIS_ID_WIDTH == 0) ? 1 : AXIS_ID_WIDTH);
  localparam int KW = NUM_CHAN * (AXIS_BUS_WIDTH / 8);

  logic [DW-1:0]       axis_egr_in_tdata,  axis_egr_out_tdata;
  logic [IW-1:0]       axis_egr_in_tid,    axis_egr_out_tid;
  logic [IW-1:0]       axis_egr_in_tdest,  axis_egr_out_tdest;
  logic [KW-1:0]       axis_egr_in_tkeep,  axis_egr_out_tkeep;
  logic [NUM_CHAN-1:0] axis_egr_in_tlast,  axis_egr_out_tlast;
  logic [NUM_CHAN-1:0] axis_egr_in_tvalid, axis_egr_out_tvalid;
  logic [NUM_CHAN-1:0] axis_egr_in_tready, axis_egr_out_tready;

  logic [DW-1:0]       axis_ingr_in_tdata,  axis_ingr_out_tdata;
  logic [IW-1:0]       axis_ingr_in_tdest,  axis_ingr_out_tdest;
  logic [KW-1:0]       axis_ingr_in_tkeep,  axis_ingr_out_tkeep;
  logic [NUM_CHAN-1:0] axis_ingr_in_tlast,  axis_ingr_out_tlast;
  logic [NUM_CHAN-1:0] axis_ingr_in_tvalid, axis_ingr_out_tvalid;
  logic [NUM_CHAN-1:0] axis_ingr_in_tready, axis_ingr_out_tready;

  modport master (
    output axis_egr_in_tdata, axis_egr_in_tid, axis_egr_in_tdest, axis_egr_in_tkeep,
    output axis_egr_in_tlast, axis_egr_in_tvalid, axis_egr_out_tready,
    input  axis_egr_in_tready, axis_egr_out_tdata, axis_egr_out_tid, axis_egr_out_tdest,
    input  axis_egr_out_tkeep, axis_egr_out_tlast, axis_egr_out_tvalid,
    output axis_ingr_in_tdata, axis_ingr_in_tdest, axis_ingr_in_tkeep, axis_ingr_in_tlast,
    output axis_ingr_in_tvalid, axis_ingr_out_tready,
    input  axis_ingr_in_tready, axis_ingr_out_tdata, axis_ingr_out_tdest, axis_ingr_out_tkeep,
    input  axis_ingr_out_tlast, axis_ingr_out_tvalid
  );

  modport slave (
    input  axis_egr_in_tdata, axis_egr_in_tid, axis_egr_in_tdest, axis_egr_in_tkeep,
    input  axis_egr_in_tlast, axis_egr_in_tvalid, axis_egr_out_tready,
    output axis_egr_in_tready, axis_egr_out_tdata, axis_egr_out_tid, axis_egr_out_tdest,
    output axis_egr_out_tkeep, axis_egr_out_tlast, axis_egr_out_tvalid,
    input  axis_ingr_in_tdata, axis_ingr_in_tdest, axis_ingr_in_tkeep, axis_ingr_in_tlast,
    input  axis_ingr_in_tvalid, axis_ingr_out_tready,
    output axis_ingr_in_tready, axis_ingr_out_tdata, axis_ingr_out_tdest, axis_ingr_out_tkeep,
    output axis_ingr_out_tlast, axis_ingr_out_tvalid
  );

endinterface

// File: rtl/net_decoup_chan.sv
// rtl/net_decoup_chan.sv - one tenant channel: egress drain FSM and ingress boundary decoupling (NET_DECOUP_DROP_CNT_EN adds drop counter)
module net_decoup_chan
  import net_decoup_pkg::*;
#(
  parameter int DRAIN_TIMEOUT              = 1024,
  parameter int DISALLOW_INGR_BACKPRESSURE = 1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic egr_in_tvalid,
  input  logic egr_in_tlast,
  input  logic egr_tlast_forced,
  output logic egr_in_tready,
  output logic egr_out_tvalid,
  input  logic egr_out_tready,
  input  logic ingr_in_tvalid,
  input  logic ingr_in_tlast,
  output logic ingr_in_tready,
  output logic ingr_out_tvalid,
  input  logic ingr_out_tready,
  input  logic decouple,
  input  logic decouple_force,
  output logic decouple_done,
  output logic egr_decoupled,
  output logic ingr_decoupled,
  output logic egr_timeout
`ifdef NET_DECOUP_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] ingr_drop_count
`endif
);
  localparam int CW = tmo_cnt_w(DRAIN_TIMEOUT);
  localparam bit TMO_EN = (DRAIN_TIMEOUT != 0);
  localparam logic [CW-1:0] TMO_LAST = CW'(DRAIN_TIMEOUT - 1);

  egr_state_e    state_q, state_d;
  logic          egr_outst_q, egr_outst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          req, egr_gate, egr_hs, egr_last;
  logic          ingr_outst_q, ingr_outst_d;
  logic          ingr_dec_q, ingr_dec_d;
  logic          ingr_hs;

  assign req      = decouple | decouple_force;
  assign egr_last = egr_in_tlast | egr_tlast_forced;
  // Idle (or forced) request blocks in the same cycle so no new packet can start.
  assign egr_gate = (state_q == EGR_DECOUPLED) |
                    ((state_q == EGR_COUPLED) & req & (~egr_outst_q | decouple_force));
  assign egr_out_tvalid = egr_in_tvalid & ~egr_gate;
  assign egr_in_tready  = egr_out_tready & ~egr_gate;
  assign egr_hs         = egr_in_tvalid & egr_in_tready;

  // Egress next state: drain to a packet boundary, force, or time out.
  always_comb begin
    state_d     = state_q;
    egr_outst_d = egr_hs ? ~egr_last : egr_outst_q;
    cnt_d       = '0;
    tmo_d       = tmo_q & decouple;
    unique case (state_q)
      EGR_COUPLED: begin
        if (req) begin
          if (egr_gate || (egr_hs && egr_last)) state_d = EGR_DECOUPLED;
          else                                  state_d = EGR_DRAIN;
        end
      end
      EGR_DRAIN: begin
        if (!req) begin
          state_d = EGR_COUPLED;
        end else if (decouple_force || (egr_hs && egr_last)) begin
          state_d = EGR_DECOUPLED;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          state_d = EGR_DECOUPLED;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EGR_DECOUPLED: begin
        if (!req) begin
          state_d     = EGR_COUPLED;
          egr_outst_d = 1'b0;
        end
      end
      default: state_d = EGR_COUPLED;
    endcase
  end

  // Egress state registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= EGR_COUPLED;
      egr_outst_q <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      egr_outst_q <= egr_outst_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign ingr_in_tready  = (DISALLOW_INGR_BACKPRESSURE != 0) ? 1'b1 : (ingr_dec_q | ingr_out_tready);
  assign ingr_out_tvalid = ingr_in_tvalid & ~ingr_dec_q;
  assign ingr_hs         = ingr_in_tvalid & ingr_in_tready;

  // Ingress: enter or leave decoupling only where no packet is in flight.
  always_comb begin
    ingr_outst_d = ingr_hs ? ~ingr_in_tlast : ingr_outst_q;
    ingr_dec_d   = ingr_dec_q;
    if (decouple_force || (decouple && !ingr_outst_d)) ingr_dec_d = 1'b1;
    else if (!decouple && !ingr_outst_d)              ingr_dec_d = 1'b0;
  end

  // Ingress state registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ingr_outst_q <= 1'b0;
      ingr_dec_q   <= 1'b0;
    end else begin
      ingr_outst_q <= ingr_outst_d;
      ingr_dec_q   <= ingr_dec_d;
    end
  end

  assign egr_decoupled  = (state_q == EGR_DECOUPLED);
  assign ingr_decoupled = ingr_dec_q;
  assign egr_timeout    = tmo_q;
  assign decouple_done  = decouple & egr_decoupled & ingr_dec_q & ~ingr_outst_q;

`ifdef NET_DECOUP_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_q;

  // Count ingress beats discarded while decoupled; saturates, survives recouple.
  always_ff @(posedge aclk) begin
    if (!aresetn) drop_q <= '0;
    else if (ingr_dec_q && ingr_hs && (drop_q != '1)) drop_q <= drop_q + 1'b1;
  end

  assign ingr_drop_count = drop_q;
`endif

endmodule

// File: rtl/net_decoupler_mc.sv
// rtl/net_decoupler_mc.sv - multi-channel per-tenant network decoupler top (NET_DECOUP_DROP_CNT_EN adds ingr_drop_count)
module net_decoupler_mc
  import net_decoup_pkg::*;
#(
  parameter int NUM_CHAN                   = 4,
  parameter int AXIS_BUS_WIDTH             = 64,
  parameter int AXIS_ID_WIDTH              = 4,
  parameter int DRAIN_TIMEOUT              = 1024,
  parameter int DISALLOW_INGR_BACKPRESSURE = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  net_decoupler_mc_if.slave     axis,
  input  logic [NUM_CHAN-1:0]   axis_egr_tlast_forced,
  input  logic [NUM_CHAN-1:0]   decouple,
  input  logic [NUM_CHAN-1:0]   decouple_force,
  output logic [NUM_CHAN-1:0]   decouple_done,
  output logic [2*NUM_CHAN-1:0] decouple_status_vector,
  output logic [NUM_CHAN-1:0]   egr_timeout
`ifdef NET_DECOUP_DROP_CNT_EN
  ,
  output logic [NUM_CHAN*DROP_CNT_W-1:0] ingr_drop_count
`endif
);
  localparam int IDW = (AXIS_ID_WIDTH == 0) ? 1 : AXIS_ID_WIDTH;
  localparam int KW  = AXIS_BUS_WIDTH / 8;

  logic [NUM_CHAN*AXIS_BUS_WIDTH-1:0] egr_tdata, ingr_tdata;
  logic [NUM_CHAN*IDW-1:0]            egr_tid, egr_tdest, ingr_tdest;
  logic [NUM_CHAN*KW-1:0]             egr_tkeep, ingr_tkeep;
  logic [NUM_CHAN-1:0]                egr_in_tready, egr_out_tvalid;
  logic [NUM_CHAN-1:0]                ingr_in_tready, ingr_out_tvalid;

  // Data and sideband are never gated, only the handshake is.
  assign egr_tdata  = axis.axis_egr_in_tdata;
  assign egr_tid    = axis.axis_egr_in_tid;
  assign egr_tdest  = axis.axis_egr_in_tdest;
  assign egr_tkeep  = axis.axis_egr_in_tkeep;
  assign ingr_tdata = axis.axis_ingr_in_tdata;
  assign ingr_tdest = axis.axis_ingr_in_tdest;
  assign ingr_tkeep = axis.axis_ingr_in_tkeep;

  assign axis.axis_egr_out_tdata   = egr_tdata;
  assign axis.axis_egr_out_tid     = egr_tid;
  assign axis.axis_egr_out_tdest   = egr_tdest;
  assign axis.axis_egr_out_tkeep   = egr_tkeep;
  assign axis.axis_egr_out_tlast   = axis.axis_egr_in_tlast;
  assign axis.axis_egr_out_tvalid  = egr_out_tvalid;
  assign axis.axis_egr_in_tready   = egr_in_tready;
  assign axis.axis_ingr_out_tdata  = ingr_tdata;
  assign axis.axis_ingr_out_tdest  = ingr_tdest;
  assign axis.axis_ingr_out_tkeep  = ingr_tkeep;
  assign axis.axis_ingr_out_tlast  = axis.axis_ingr_in_tlast;
  assign axis.axis_ingr_out_tvalid = ingr_out_tvalid;
  assign axis.axis_ingr_in_tready  = ingr_in_tready;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    net_decoup_chan #(
      .DRAIN_TIMEOUT              (DRAIN_TIMEOUT),
      .DISALLOW_INGR_BACKPRESSURE (DISALLOW_INGR_BACKPRESSURE)
    ) u_chan (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .egr_in_tvalid    (axis.axis_egr_in_tvalid[c]),
      .egr_in_tlast     (axis.axis_egr_in_tlast[c]),
      .egr_tlast_forced (axis_egr_tlast_forced[c]),
      .egr_in_tready    (egr_in_tready[c]),
      .egr_out_tvalid   (egr_out_tvalid[c]),
      .egr_out_tready   (axis.axis_egr_out_tready[c]),
      .ingr_in_tvalid   (axis.axis_ingr_in_tvalid[c]),
      .ingr_in_tlast    (axis.axis_ingr_in_tlast[c]),
      .ingr_in_tready   (ingr_in_tready[c]),
      .ingr_out_tvalid  (ingr_out_tvalid[c]),
      .ingr_out_tready  (axis.axis_ingr_out_tready[c]),
      .decouple         (decouple[c]),
      .decouple_force   (decouple_force[c]),
      .decouple_done    (decouple_done[c]),
      .egr_decoupled    (decouple_status_vector[2*c]),
      .ingr_decoupled   (decouple_status_vector[2*c+1]),
      .egr_timeout      (egr_timeout[c])
`ifdef NET_DECOUP_DROP_CNT_EN
      ,
      .ingr_drop_count  (ingr_drop_count[c*DROP_CNT_W +: DROP_CNT_W])
`endif
    );
  end

endmodule
